// File: rtl/atom_kbd_pkg.sv
// atom_kbd_pkg: decoder states, PS/2 byte constants and the set-2 to Atom matrix table
package atom_kbd_pkg;

    typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_SKIP} kbd_state_t;

    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_OVR0   = 8'h00;
    localparam logic [7:0] PS2_OVR1   = 8'hFF;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;
    localparam logic [2:0] PAUSE_LEN  = 3'd7;
    localparam logic [3:0] ROW_MAX    = 4'd9;

    typedef enum logic [1:0] {K_KEY, K_SHIFT, K_CTRL, K_REPT} kbd_kind_t;

    typedef struct packed {
        kbd_kind_t  kind;
        logic [3:0] row;
        logic [2:0] col;
    } kbd_hit_t;

    // A miss is a matrix key aimed at a row that does not exist, so it never writes.
    localparam kbd_hit_t KBD_MISS = '{kind: K_KEY, row: 4'hF, col: 3'd0};

    function automatic logic ps2_ignored(input logic [7:0] b);
        return b inside {PS2_BAT, PS2_ACK, PS2_RESEND, PS2_ECHO, PS2_OVR0, PS2_OVR1};
    endfunction

    function automatic kbd_hit_t kbd_key(input logic [3:0] r, input logic [2:0] c);
        return '{kind: K_KEY, row: r, col: c};
    endfunction

    function automatic kbd_hit_t kbd_map(input logic ext, input logic [7:0] code);
        kbd_hit_t h;
        h = KBD_MISS;
        case ({ext, code})
            9'h012, 9'h059: h.kind = K_SHIFT;
            9'h014, 9'h114: h.kind = K_CTRL;
            9'h011:         h.kind = K_REPT;
            9'h066: h = kbd_key(4'd0, 3'd0);
            9'h026: h = kbd_key(4'd0, 3'd1);
            9'h04E: h = kbd_key(4'd0, 3'd2);
            9'h034: h = kbd_key(4'd0, 3'd3);
            9'h015: h = kbd_key(4'd0, 3'd4);
            9'h076: h = kbd_key(4'd0, 3'd5);
            9'h058: h = kbd_key(4'd1, 3'd0);
            9'h01E: h = kbd_key(4'd1, 3'd1);
            9'h041: h = kbd_key(4'd1, 3'd2);
            9'h02B: h = kbd_key(4'd1, 3'd3);
            9'h04D: h = kbd_key(4'd1, 3'd4);
            9'h01A: h = kbd_key(4'd1, 3'd5);
            9'h172: h = kbd_key(4'd2, 3'd0);
            9'h016: h = kbd_key(4'd2, 3'd1);
            9'h04C: h = kbd_key(4'd2, 3'd2);
            9'h024: h = kbd_key(4'd2, 3'd3);
            9'h044: h = kbd_key(4'd2, 3'd4);
            9'h035: h = kbd_key(4'd2, 3'd5);
            9'h174: h = kbd_key(4'd3, 3'd0);
            9'h045: h = kbd_key(4'd3, 3'd1);
            9'h052: h = kbd_key(4'd3, 3'd2);
            9'h023: h = kbd_key(4'd3, 3'd3);
            9'h031: h = kbd_key(4'd3, 3'd4);
            9'h175: h = kbd_key(4'd3, 3'd5);
            9'h16B: h = kbd_key(4'd4, 3'd0);
            9'h046: h = kbd_key(4'd4, 3'd1);
            9'h049: h = kbd_key(4'd4, 3'd2);
            9'h021: h = kbd_key(4'd4, 3'd3);
            9'h03A: h = kbd_key(4'd4, 3'd4);
            9'h022: h = kbd_key(4'd4, 3'd5);
            9'h00E: h = kbd_key(4'd5, 3'd0);
            9'h00D: h = kbd_key(4'd5, 3'd1);
            9'h03E: h = kbd_key(4'd5, 3'd2);
            9'h032: h = kbd_key(4'd5, 3'd3);
            9'h04B: h = kbd_key(4'd5, 3'd4);
            9'h02A: h = kbd_key(4'd5, 3'd5);
            9'h05B: h = kbd_key(4'd6, 3'd0);
            9'h05A: h = kbd_key(4'd6, 3'd1);
            9'h03D: h = kbd_key(4'd6, 3'd2);
            9'h02C: h = kbd_key(4'd6, 3'd3);
            9'h01C: h = kbd_key(4'd6, 3'd4);
            9'h03C: h = kbd_key(4'd6, 3'd5);
            9'h05D: h = kbd_key(4'd7, 3'd0);
            9'h04A: h = kbd_key(4'd7, 3'd1);
            9'h036: h = kbd_key(4'd7, 3'd2);
            9'h02D: h = kbd_key(4'd7, 3'd3);
            9'h042: h = kbd_key(4'd7, 3'd4);
            9'h01D: h = kbd_key(4'd7, 3'd5);
            9'h054: h = kbd_key(4'd8, 3'd0);
            9'h033: h = kbd_key(4'd8, 3'd1);
            9'h02E: h = kbd_key(4'd8, 3'd2);
            9'h03B: h = kbd_key(4'd8, 3'd3);
            9'h043: h = kbd_key(4'd8, 3'd4);
            9'h01B: h = kbd_key(4'd8, 3'd5);
            9'h029: h = kbd_key(4'd9, 3'd0);
            9'h055: h = kbd_key(4'd9, 3'd1);
            9'h025: h = kbd_key(4'd9, 3'd2);
            9'h15A: h = kbd_key(4'd9, 3'd3);
            9'h171: h = kbd_key(4'd9, 3'd4);
            9'h170: h = kbd_key(4'd9, 3'd5);
            default: h = KBD_MISS;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/atom_ps2_keyboard_ps2_rx.sv
// ps2_rx: PS/2 receiver with input synchroniser, falling-edge sampling, parity check and timeout
module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev, fall, bit_in, frame_ok;
    logic [3:0]             bit_cnt;
    logic [9:0]             shreg;
    logic [TW-1:0]          idle_cnt;

    assign bit_in   = data_sync[SYNC_STAGES-1];
    assign fall     = clk_prev & ~clk_sync[SYNC_STAGES-1];
    // shreg holds start, data[7:0], parity; bit_in is the stop bit on the 11th edge
    assign frame_ok = ~shreg[0] & bit_in & ^shreg[9:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            idle_cnt   <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt    <= '0;
                    byte_valid <= frame_ok;
                    frame_err  <= ~frame_ok;
                    byte_data  <= shreg[8:1];
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {bit_in, shreg[9:1]};
                end
            end else if (bit_cnt != 4'd0) begin
                if (idle_cnt == TW'(TIMEOUT_CYCLES)) begin
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/atom_ps2_keyboard.sv
// atom_ps2_keyboard: PS/2 set-2 to Atom 10x6 key matrix for the PIO; KBD_LAST_CODE_EN adds last_code/last_ext
module atom_ps2_keyboard
    import atom_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [3:0] key_row,
    input  logic       vsync_n,
    output logic [9:0] pio_input,
    output logic       frame_err
`ifdef KBD_LAST_CODE_EN
    ,
    output logic [7:0] last_code,
    output logic       last_ext
`endif
);
    logic       byte_valid;
    logic [7:0] byte_data;
    kbd_state_t state, state_nx;
    logic [2:0] skip_cnt, skip_nx;
    logic       key_act, key_brk, key_ext;
    kbd_hit_t   hit;
    logic [5:0] matrix [0:9];
    logic       ctrl, shift, rept;
    logic [5:0] row_bits;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_nx;
            skip_cnt <= skip_nx;
        end
    end

    always_comb begin
        state_nx = state;
        skip_nx  = skip_cnt;
        key_act  = 1'b0;
        key_brk  = 1'b0;
        key_ext  = 1'b0;
        if (byte_valid) begin
            case (state)
                S_IDLE: begin
                    if (byte_data == PS2_BRK) state_nx = S_BRK;
                    else if (byte_data == PS2_EXT) state_nx = S_EXT;
                    else if (byte_data == PS2_PAUSE) begin
                        state_nx = S_SKIP;
                        skip_nx  = PAUSE_LEN;
                    end else key_act = ~ps2_ignored(byte_data);
                end
                S_BRK: begin
                    state_nx = S_IDLE;
                    key_act  = 1'b1;
                    key_brk  = 1'b1;
                end
                S_EXT: begin
                    key_ext  = 1'b1;
                    state_nx = (byte_data == PS2_BRK) ? S_EXT_BRK : S_IDLE;
                    key_act  = (byte_data != PS2_BRK) && (byte_data != PS2_LSHIFT) && (byte_data != PS2_RSHIFT);
                end
                S_EXT_BRK: begin
                    state_nx = S_IDLE;
                    key_act  = 1'b1;
                    key_brk  = 1'b1;
                    key_ext  = 1'b1;
                end
                S_SKIP: begin
                    skip_nx  = skip_cnt - 3'd1;
                    state_nx = (skip_cnt == 3'd1) ? S_IDLE : S_SKIP;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    assign hit = kbd_map(key_ext, byte_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            matrix <= '{default: '0};
            ctrl   <= 1'b0;
            shift  <= 1'b0;
            rept   <= 1'b0;
        end else if (key_act) begin
            case (hit.kind)
                K_SHIFT: shift <= ~key_brk;
                K_CTRL:  ctrl  <= ~key_brk;
                K_REPT:  rept  <= ~key_brk;
                default: if (hit.row <= ROW_MAX) matrix[hit.row][hit.col] <= ~key_brk;
            endcase
        end
    end

`ifdef KBD_LAST_CODE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_code <= '0;
            last_ext  <= 1'b0;
        end else if (key_act) begin
            last_code <= byte_data;
            last_ext  <= key_ext;
        end
    end
`endif

    assign row_bits  = (key_row <= ROW_MAX) ? ~matrix[key_row] : 6'h3F;
    assign pio_input = {vsync_n, ~rept, ~shift, ~ctrl, row_bits};

endmodule

// File: tb/tb_atom_ps2_keyboard.sv
// tb_atom_ps2_keyboard: randomized PS/2 key events checked against an event-level key-state model
module tb_atom_ps2_keyboard;
    localparam int TO = 300;
    localparam int H  = 8;

    logic       clk = 1'b0;
    logic       reset, ps2_clk, ps2_data, vsync_n, frame_err;
    logic [3:0] key_row;
    logic [9:0] pio_input;

    atom_ps2_keyboard #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_row  (key_row),
        .vsync_n  (vsync_n),
        .pio_input(pio_input),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // key table: {ext,code}; row 10=shift 11=ctrl 12=rept 13=no action
    bit [8:0] kc [15]   = '{9'h01C, 9'h029, 9'h05A, 9'h175, 9'h02B, 9'h045, 9'h04A, 9'h16B,
                            9'h012, 9'h059, 9'h014, 9'h114, 9'h011, 9'h005, 9'h111};
    int       kr [15]   = '{6, 9, 6, 3, 1, 3, 7, 4, 10, 10, 11, 11, 12, 13, 13};
    int       kcol [15] = '{4, 0, 1, 5, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    bit [7:0] ign [6]   = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    bit [7:0] pause [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    bit [5:0] mat [10];
    bit       m_ctrl, m_shift, m_rept;
    int       m_fe = 0;

    int         vec = 0, err = 0, fe_cnt = 0;
    bit         chk_en = 0;
    int         lit_seq = 0, lit_done = 0, lit_kind, lit_exp;
    logic [9:0] lit_mask;
    string      lit_name;

    function automatic logic [9:0] exp_pio(input logic [3:0] r, input logic vs);
        logic [5:0] c;
        c = (r <= 4'd9) ? ~mat[r] : 6'h3F;
        return {vs, ~m_rept, ~m_shift, ~m_ctrl, c};
    endfunction

    always @(negedge clk) begin
        int got;
        if (frame_err) fe_cnt++;
        if (chk_en) begin
            vec++;
            if (pio_input !== exp_pio(key_row, vsync_n)) begin
                err++;
                $display("FAIL pio_word row=%0d got=%h want=%h", key_row, pio_input, exp_pio(key_row, vsync_n));
            end
        end
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            vec++;
            got = lit_kind ? fe_cnt : 32'(pio_input & lit_mask);
            if (got != lit_exp) begin
                err++;
                $display("FAIL %s got=%h want=%h", lit_name, got, lit_exp);
            end
        end
    end

    task automatic lit(input string nm, input int kind, input logic [9:0] mask, input int want);
        @(posedge clk);
        lit_name = nm; lit_kind = kind; lit_mask = mask; lit_exp = want;
        lit_seq++;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [10:0] frm(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        chk_en = 0;
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (H) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(frm(b), 11);
    endtask

    task automatic idle(input int n);
        chk_en = 1;
        repeat (n) begin
            @(posedge clk);
            key_row = 4'($urandom_range(0, 15));
            vsync_n = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic model_clear();
        foreach (mat[i]) mat[i] = '0;
        m_ctrl = 0; m_shift = 0; m_rept = 0;
    endtask

    task automatic send_key(input int k, input bit brk);
        if (kc[k][8]) send_byte(8'hE0);
        if (brk) send_byte(8'hF0);
        send_byte(kc[k][7:0]);
        case (kr[k])
            10: m_shift = ~brk;
            11: m_ctrl  = ~brk;
            12: m_rept  = ~brk;
            13: ;
            default: mat[kr[k]][kcol[k]] = ~brk;
        endcase
        idle(6);
    endtask

    task automatic send_pause();
        foreach (pause[i]) begin
            send_byte(pause[i]);
            idle(3);
        end
    endtask

    initial begin
        ps2_clk = 1; ps2_data = 1; key_row = 0; vsync_n = 1; reset = 1;
        model_clear();
        idle(3);
        key_row = 0;
        lit("reset_word", 0, 10'h3FF, {22'd0, vsync_n, 9'h1FF});
        reset = 0;
        idle(4);
        send_key(0, 0); key_row = 6; lit("a_make", 0, 10'h03F, 'h2F);
        send_key(0, 1); key_row = 6; lit("a_break", 0, 10'h03F, 'h3F);
        send_key(8, 0); key_row = 0; lit("shift_make", 0, 10'h0BF, 'h03F);
        send_byte(8'hE0); send_byte(8'h12); idle(6);
        key_row = 0; lit("fake_shift", 0, 10'h0BF, 'h03F);
        send_key(8, 1); key_row = 0; lit("shift_break", 0, 10'h080, 'h080);
        send_bits(frm(8'h29) ^ 11'h200, 11); m_fe++; idle(6);
        key_row = 9; lit("bad_par_row", 0, 10'h03F, 'h3F);
        lit("bad_par_err", 1, '0, 1);
        send_bits(frm(8'h5A), 6);
        repeat (TO + 2) @(posedge clk);
        send_key(2, 0); key_row = 6; lit("timeout_ret", 0, 10'h03F, 'h3D);
        lit("timeout_noerr", 1, '0, m_fe);
        send_key(2, 1);
        send_pause();
        send_key(3, 0); key_row = 3; lit("up_after_pause", 0, 10'h03F, 'h1F);
        for (int r = 10; r < 16; r++) begin
            key_row = 4'(r);
            lit("row_hi", 0, 10'h03F, 'h3F);
        end
        send_key(3, 1);
        send_key(0, 0); send_key(1, 0);
        send_bits(frm(8'h1C), 4);
        reset = 1; model_clear();
        idle(3);
        reset = 0;
        idle(3);
        key_row = 6; lit("rst_row6", 0, 10'h03F, 'h3F);
        key_row = 9; lit("rst_row9", 0, 10'h1FF, 'h1FF);
        send_key(1, 0); key_row = 9; lit("post_rst_space", 0, 10'h03F, 'h3E);
        send_key(1, 1);
        for (int n = 0; n < 90; n++) begin
            int t;
            t = $urandom_range(0, 11);
            if (t <= 6) send_key($urandom_range(0, 14), 1'($urandom_range(0, 1)));
            else if (t == 7) begin
                send_byte(ign[$urandom_range(0, 5)]); idle(4);
            end else if (t == 8) begin
                send_byte(8'hE0);
                if ($urandom_range(0, 1) == 1) send_byte(8'hF0);
                send_byte($urandom_range(0, 1) ? 8'h12 : 8'h59);
                idle(4);
            end else if (t == 9) begin
                logic [10:0] bad;
                bad = (t == 9) ? 11'h001 << (($urandom_range(0, 2) == 0) ? 0 : ($urandom_range(0, 1) ? 9 : 10)) : 11'h0;
                send_bits(frm(8'($urandom)) ^ bad, 11); m_fe++; idle(4);
                lit("rand_bad_err", 1, '0, m_fe);
            end else if (t == 10) send_pause();
            else idle(12);
        end
        lit("final_err_count", 1, '0, m_fe);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
